config_loader: RTL
==================

# config_loader

Bit-serial configuration loader sitting directly upstream of the config tile shift chains. Accepts configuration words from the host/bitstream port over a valid/ready handshake, serializes them LSB-first onto either the hard or the soft shift chain with `shift_enable`, and, after exactly `CHAIN_LEN` bits, issues a one-cycle `set_soft`/`set_hard` pulse so the config latches capture the shifted data.

## Interface
Parameters:
- `CHAIN_LEN`, 12, total bits in the target chain (all tiles, comb + mem + ctrl bits); ≥ 1
- `WORD_W`, 8, host word width; ≥ 1

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a load; sampled only in IDLE
- `sel_hard`  in  1  latched at `start`: 1 = drive `shift_in_hard`, 0 = drive `shift_in_soft`
- `set_mask`  in  2  latched at `start`: bit0 enables the `set_soft` pulse, bit1 enables the `set_hard` pulse
- `abort`  in  1  synchronous cancel; return to IDLE with no set pulse
- `in_data`  in  WORD_W  configuration word; bit 0 is shifted first
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a word this cycle
- `shift_in_hard`  out  1  serial data to hard chain
- `shift_in_soft`  out  1  serial data to soft chain
- `shift_enable`  out  1  chain shifts on the next rising edge
- `set_soft`  out  1  one-cycle latch pulse, soft
- `set_hard`  out  1  one-cycle latch pulse, hard
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after a completed load

## Operation
- FSM states: IDLE, LOAD, SHIFT, SET, DONE.
- IDLE: `start`=1 → latch `sel_hard`, `set_mask`; clear bit counter; go to LOAD.
- LOAD: `in_ready`=1. On `in_valid && in_ready`, capture `in_data` into the shift register and go to SHIFT.
- SHIFT: each cycle, present one bit (register LSB) on the selected chain output with `shift_enable`=1, then shift the register right and increment the bit counter.
  - Exit SHIFT after `WORD_W` bits → LOAD, or as soon as the counter reaches `CHAIN_LEN` → SET.
  - Upper bits of the final word beyond `CHAIN_LEN` are discarded and never shifted.
- SET: exactly one cycle, `shift_enable`=0.
  - `set_soft` = `set_mask[0]`, `set_hard` = `set_mask[1]`.
  - Then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Unselected chain output held 0. Both chain outputs are 0 when `shift_enable`=0.
- Bit counter width is `$clog2(CHAIN_LEN+1)`. It never exceeds `CHAIN_LEN`.
- `abort` in LOAD/SHIFT/SET → IDLE next cycle: no set pulse, no `done`, no handshake in that cycle (`in_ready` is forced 0 while `abort`=1). Bits already shifted are left in the chain. `abort` in IDLE/DONE is ignored.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE → `start` wins.
- `set_mask`=0 still runs SET/DONE, with no pulses on `set_soft`/`set_hard`.

## Timing
- All outputs are registered (driven from state flops). No combinational path from any input to any output except `in_ready`, which is a decode of state and `abort`.
- Reset values: state IDLE; all outputs 0; counter 0; latched mode 0.
- Async `rst` mid-load: outputs go to 0 immediately and no set pulse is issued. The chain keeps its partial contents.
- Cycle n = interval after rising edge n. With `start` sampled at edge 0 and `in_valid` held high:
  - LOAD in cycle 0; handshake at edge 1.
  - Bits 0..`WORD_W`-1 shift in cycles 1..`WORD_W`.
  - LOAD in cycle `WORD_W`+1.
- Each word costs one LOAD cycle plus its shift cycles.
- Total latency from `start` to the SET cycle = `CHAIN_LEN` + ceil(`CHAIN_LEN`/`WORD_W`) cycles, plus any LOAD cycles spent waiting on `in_valid`.
- `in_valid` low in LOAD stalls indefinitely. `shift_enable` stays 0 while stalled.
- Downstream chain captures cycle-n data at edge n+1.

## Test plan
- CHAIN_LEN=12, WORD_W=8, `sel_hard`=1, `set_mask`=2'b11, words 0x07 then 0xF3 → `shift_in_hard` sequence 1,1,1,0,0,0,0,0,1,1,0,0 in cycles 1–8 and 10–13; `set_hard`=`set_soft`=1 in cycle 14 only; `done` in cycle 15; latched comb/mem = 5'b11000 / 5'b00111.
- Same config with `sel_hard`=0, `set_mask`=2'b01 → data only on `shift_in_soft`, `shift_in_hard` stays 0, and only `set_soft` pulses.
- `in_valid` withheld 5 cycles before the second word → `shift_enable` low during the gap; SET moves to cycle 19; the shifted bit sequence is unchanged.
- `abort` in cycle 5 of the first word → `shift_enable` low from cycle 6; no `set_*`, no `done`; `busy` 0 from cycle 6; a new `start` then completes normally.
- `rst` asserted mid-SHIFT → all outputs 0 asynchronously and state IDLE. `start` asserted while `busy`=1 → ignored; the running load finishes with exactly 12 shifted bits.

Source files
------------

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_loader
// Brief    : Bit-serial config loader. It takes host words over valid/ready,
//            shifts them LSB-first onto the hard or soft chain, then pulses
//            the set latches.
// Revision : 1.0
// ============================================================================
module config_loader #(
    parameter int CHAIN_LEN = 12,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sel_hard,
    input  logic [1:0]        set_mask,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_in_hard,
    output logic              shift_in_soft,
    output logic              shift_enable,
    output logic              set_soft,
    output logic              set_hard,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SET   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic [1:0]          mask_q, mask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [WORD_W-1:0]   sreg_q, sreg_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            mask_q  <= 2'b00;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            sreg_q  <= sreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        sreg_d  = sreg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = sel_hard;
                    mask_d  = set_mask;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    sreg_d  = in_data;
                    wcnt_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q + 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                    // Chain-full check wins so surplus bits of the last word are dropped.
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SET;
                    end else if (wcnt_q == WCNT_LAST) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_SET: begin
                state_d = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode flops only; in_ready is the single path that also sees abort.
    assign in_ready      = (state_q == S_LOAD) && !abort;
    assign shift_enable  = (state_q == S_SHIFT);
    assign shift_in_hard = shift_enable &&  sel_q && sreg_q[0];
    assign shift_in_soft = shift_enable && !sel_q && sreg_q[0];
    assign set_soft      = (state_q == S_SET) && mask_q[0];
    assign set_hard      = (state_q == S_SET) && mask_q[1];
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

endmodule
`default_nettype wire
